// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO bus arbiter: serialises 1/2/4-byte fetch and load/store
// accesses into byte cycles and assembles little-endian words.
module mem_arbiter #(
   parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        flush,
   input  logic        io_buffer_full,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [1:0]  ls_len,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr
);

   typedef enum logic [2:0] {S_IDLE, S_IF_RD, S_LS_RD, S_LS_WR, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  nbytes_q, nbytes_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] data_q, data_d;
   logic        owner_ls_q, owner_ls_d;
   logic        last_ls_q, last_ls_d;
   logic        stall_q;

   logic        if_ok, ls_ok, grant_ls, grant_if;
   logic [2:0]  cnt_eff;
   logic [1:0]  byte_idx;
   logic        wr_d;

   // A read that was paused restarts from byte 0: the bytes already in
   // flight on the RAM port no longer match the counter.
   assign cnt_eff  = stall_q ? 3'd0 : cnt_q;
   assign byte_idx = cnt_eff[1:0] - 2'd1;

   assign if_data  = data_q;
   assign ls_rdata = data_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      nbytes_d   = nbytes_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      data_d     = data_q;
      owner_ls_d = owner_ls_q;
      last_ls_d  = last_ls_q;
      if_done    = 1'b0;
      ls_done    = 1'b0;
      mem_a      = '0;
      mem_dout   = '0;
      wr_d       = 1'b0;
      if_ok      = if_req && !flush;
      ls_ok      = ls_req && !(ls_wr && (ls_addr >= IO_BASE) && io_buffer_full);
      grant_ls   = ls_ok && (!if_ok || !last_ls_q);
      grant_if   = if_ok && !grant_ls;

      case (state_q)
         S_IDLE: begin
            if (grant_ls) begin
               owner_ls_d = 1'b1;
               last_ls_d  = 1'b1;
               addr_d     = ls_addr;
               wdata_d    = ls_wdata;
               nbytes_d   = (ls_len == 2'd0) ? 3'd1 : (ls_len == 2'd1) ? 3'd2 : 3'd4;
               cnt_d      = '0;
               data_d     = '0;
               state_d    = ls_wr ? S_LS_WR : S_LS_RD;
            end else if (grant_if) begin
               owner_ls_d = 1'b0;
               last_ls_d  = 1'b0;
               addr_d     = if_addr;
               nbytes_d   = 3'd4;
               cnt_d      = '0;
               data_d     = '0;
               state_d    = S_IF_RD;
            end
         end
         S_IF_RD, S_LS_RD: begin
            if (stall_q)
               data_d = '0;
            if (cnt_eff < nbytes_q)
               mem_a = addr_q + {29'd0, cnt_eff};
            if (cnt_eff != 3'd0)
               data_d[{byte_idx, 3'b000} +: 8] = mem_din;
            cnt_d = cnt_eff + 3'd1;
            if (cnt_eff == nbytes_q) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end
            if (state_q == S_IF_RD && flush) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         S_LS_WR: begin
            mem_a    = addr_q + {29'd0, cnt_q};
            mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            wr_d     = 1'b1;
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == nbytes_q - 3'd1) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if_done = !owner_ls_q;
            ls_done = owner_ls_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (!rdy_in) begin
         if_done = 1'b0;
         ls_done = 1'b0;
      end
   end

   assign mem_wr = wr_d && rdy_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         nbytes_q   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         data_q     <= '0;
         owner_ls_q <= 1'b0;
         last_ls_q  <= 1'b0;
         stall_q    <= 1'b0;
      end else begin
         stall_q <= !rdy_in;
         if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nbytes_q   <= nbytes_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            owner_ls_q <= owner_ls_d;
            last_ls_q  <= last_ls_d;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a one-cycle-latency RAM model.
module tb_mem_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, flush, io_buffer_full;
   logic        if_req, if_done, ls_req, ls_wr, ls_done, mem_wr;
   logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata, mem_a;
   logic [1:0]  ls_len;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        is_load;
      logic [31:0] data;
   } ls_exp_t;

   logic [31:0] exp_if[$];
   ls_exp_t     exp_ls[$];
   logic [7:0]  wmem[logic [31:0]];

   mem_arbiter #(.IO_BASE(32'h0003_0000)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
      .io_buffer_full(io_buffer_full),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      if (wmem.exists(a)) return wmem[a];
      return a[7:0] ^ 8'h5A;
   endfunction

   function automatic logic [31:0] rd_word(input logic [31:0] a, input int unsigned n);
      logic [31:0] w = '0;
      for (int unsigned i = 0; i < n; i++) w[8*i +: 8] = ram_rd(a + i);
      return w;
   endfunction

   always @(posedge clk_in) begin
      if (mem_wr) wmem[mem_a] = mem_dout;
      mem_din <= ram_rd(mem_a);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_ls(input logic is_load, input logic [31:0] d);
      ls_exp_t e;
      e.is_load = is_load;
      e.data    = d;
      exp_ls.push_back(e);
   endtask

   // Advance to the middle of the next cycle and retire any done pulses
   // against the scoreboard.
   task automatic tick();
      logic [31:0] e;
      ls_exp_t     s;
      @(negedge clk_in);
      if (if_done) begin
         if (exp_if.size() == 0) chk("if_done_unexpected", 32'(if_done), 32'd0);
         else begin
            e = exp_if.pop_front();
            chk("if_data", if_data, e);
         end
      end
      if (ls_done) begin
         if (exp_ls.size() == 0) chk("ls_done_unexpected", 32'(ls_done), 32'd0);
         else begin
            s = exp_ls.pop_front();
            if (s.is_load) chk("ls_rdata", ls_rdata, s.data);
         end
      end
      if (!rdy_in) chk("wr_while_paused", 32'(mem_wr), 32'd0);
   endtask

   task automatic bus(input string tag, input logic [31:0] a, input logic wr, input logic [7:0] d);
      chk({tag, "_a"}, mem_a, a);
      chk({tag, "_wr"}, 32'(mem_wr), 32'(wr));
      if (wr) chk({tag, "_dout"}, 32'(mem_dout), 32'(d));
   endtask

   initial begin
      logic [31:0] ea;
      rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wr = 1'b0; ls_len = '0;
      ls_addr = '0; ls_wdata = '0;
      wmem[32'h0] = 8'h13; wmem[32'h1] = 8'h05; wmem[32'h2] = 8'h00; wmem[32'h3] = 8'h00;
      tick(); tick();
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_dout", 32'(mem_dout), 32'd0);
      chk("rst_if_done", 32'(if_done), 32'd0);
      chk("rst_ls_done", 32'(ls_done), 32'd0);
      chk("rst_if_data", if_data, 32'd0);
      chk("rst_ls_rdata", ls_rdata, 32'd0);
      rst_in = 1'b0;
      tick();

      // Word fetch from 0x0
      if_req = 1'b1; if_addr = 32'h0;
      exp_if.push_back(32'h0000_0513);
      for (int i = 0; i < 4; i++) begin
         tick();
         bus("t1_rd", 32'(i), 1'b0, 8'h00);
      end
      tick();
      bus("t1_c5", 32'h0, 1'b0, 8'h00);
      chk("t1_no_done_c5", 32'(if_done), 32'd0);
      tick();
      chk("t1_if_done_c6", 32'(if_done), 32'd1);
      if_req = 1'b0;
      tick();
      chk("t1_single_pulse", 32'(if_done), 32'd0);

      // Reset in the middle of a fetch: bus idle immediately, no done
      if_req = 1'b1; if_addr = 32'h10;
      tick();
      bus("rst_mid_c1", 32'h10, 1'b0, 8'h00);
      tick();
      rst_in = 1'b1;
      #1;
      chk("rst_mid_mem_a", mem_a, 32'd0);
      if_req = 1'b0;
      tick();
      rst_in = 1'b0;
      tick();

      // Simultaneous requests after reset: load wins, fetch follows
      if_req = 1'b1; if_addr = 32'h40;
      ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'd2; ls_addr = 32'h100;
      push_ls(1'b1, rd_word(32'h100, 4));
      exp_if.push_back(rd_word(32'h40, 4));
      for (int c = 1; c <= 13; c++) begin
         tick();
         if (c <= 4) ea = 32'h100 + 32'(c - 1);
         else if (c >= 8 && c <= 11) ea = 32'h40 + 32'(c - 8);
         else ea = 32'h0;
         chk("t2_addr", mem_a, ea);
         chk("t2_wr", 32'(mem_wr), 32'd0);
         if (c == 6) begin
            chk("t2_ls_first", 32'(ls_done), 32'd1);
            chk("t2_if_waits", 32'(if_done), 32'd0);
            ls_req = 1'b0;
         end
         if (c == 13) begin
            chk("t2_if_done", 32'(if_done), 32'd1);
            if_req = 1'b0;
         end
      end
      tick();

      // Half store then half load readback (upper bytes zero)
      ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'd1; ls_addr = 32'h200; ls_wdata = 32'hAABB_CCDD;
      push_ls(1'b0, 32'h0);
      tick(); bus("t3_b0", 32'h200, 1'b1, 8'hDD);
      tick(); bus("t3_b1", 32'h201, 1'b1, 8'hCC);
      tick();
      chk("t3_ls_done", 32'(ls_done), 32'd1);
      bus("t3_done_bus", 32'h0, 1'b0, 8'h00);
      ls_req = 1'b0;
      tick();
      ls_req = 1'b1; ls_wr = 1'b0;
      push_ls(1'b1, 32'h0000_CCDD);
      tick(); tick(); tick(); tick();
      chk("t3_rb_done", 32'(ls_done), 32'd1);
      ls_req = 1'b0;
      tick();

      // IO store held off while the buffer is full
      io_buffer_full = 1'b1;
      ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h1234_5677;
      push_ls(1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_held_wr", 32'(mem_wr), 32'd0);
         chk("t4_no_done", 32'(ls_done), 32'd0);
      end
      io_buffer_full = 1'b0;
      tick(); bus("t4_io_wr", 32'h0003_0000, 1'b1, 8'h77);
      tick(); chk("t4_ls_done", 32'(ls_done), 32'd1);
      ls_req = 1'b0;
      tick();
      // Just below IO_BASE is plain RAM: not gated by the full flag
      io_buffer_full = 1'b1;
      ls_req = 1'b1; ls_addr = 32'h0002_FFFF; ls_wdata = 32'h0000_005C;
      push_ls(1'b0, 32'h0);
      tick(); bus("t4_ram_wr", 32'h0002_FFFF, 1'b1, 8'h5C);
      tick(); chk("t4_ram_done", 32'(ls_done), 32'd1);
      ls_req = 1'b0; io_buffer_full = 1'b0;
      tick();

      // Flush aborts fetch in C3; pending byte load granted next
      if_req = 1'b1; if_addr = 32'h80;
      ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'd0; ls_addr = 32'h123;
      push_ls(1'b1, {24'h0, ram_rd(32'h123)});
      tick(); bus("t5_c1", 32'h80, 1'b0, 8'h00);
      tick(); bus("t5_c2", 32'h81, 1'b0, 8'h00);
      tick(); bus("t5_c3", 32'h82, 1'b0, 8'h00);
      flush = 1'b1; if_req = 1'b0;
      tick();
      chk("t5_idle_addr", mem_a, 32'h0);
      chk("t5_no_if_done", 32'(if_done), 32'd0);
      flush = 1'b0;
      tick(); bus("t5_ls_rd", 32'h123, 1'b0, 8'h00);
      tick(); bus("t5_ls_c2", 32'h0, 1'b0, 8'h00);
      tick(); chk("t5_ls_done", 32'(ls_done), 32'd1);
      ls_req = 1'b0;
      tick();

      // Word store paused one edge: resumes at the held byte
      ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'd2; ls_addr = 32'h400; ls_wdata = 32'h1122_3344;
      push_ls(1'b0, 32'h0);
      tick(); bus("t6w_b0", 32'h400, 1'b1, 8'h44);
      tick(); bus("t6w_b1", 32'h401, 1'b1, 8'h33);
      rdy_in = 1'b0;
      tick(); bus("t6w_paused", 32'h401, 1'b0, 8'h00);
      rdy_in = 1'b1;
      tick(); bus("t6w_b2", 32'h402, 1'b1, 8'h22);
      tick(); bus("t6w_b3", 32'h403, 1'b1, 8'h11);
      tick(); chk("t6w_done", 32'(ls_done), 32'd1);
      ls_req = 1'b0;
      tick();

      // Word load paused for two edges: restarts from byte 0
      ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'd3;
      push_ls(1'b1, 32'h1122_3344);
      tick(); bus("t6r_c1", 32'h400, 1'b0, 8'h00);
      tick(); bus("t6r_c2", 32'h401, 1'b0, 8'h00);
      rdy_in = 1'b0;
      tick(); chk("t6r_c3_no_done", 32'(ls_done), 32'd0);
      tick(); bus("t6r_restart", 32'h400, 1'b0, 8'h00);
      rdy_in = 1'b1;
      for (int c = 5; c <= 8; c++) begin
         tick();
         ea = (c <= 7) ? 32'h400 + 32'(c - 4) : 32'h0;
         chk("t6r_addr", mem_a, ea);
         chk("t6r_not_yet", 32'(ls_done), 32'd0);
      end
      tick(); chk("t6r_done_c9", 32'(ls_done), 32'd1);
      ls_req = 1'b0;
      tick(); tick();

      chk("if_sb_empty", 32'(exp_if.size()), 32'd0);
      chk("ls_sb_empty", 32'(exp_ls.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
